boot_loader: RTL
================

Name: boot_loader

Overview:
- Sequences CPU start-up.
- Holds the cpu in reset while a serial byte stream is received, assembled into 16-bit instruction words and written into instruction memory from address 0.
- After the frame's checksum verifies, releases cpu reset.
- Sits between the host/UART byte receiver and the instruction ROM write port / cpu reset input.

Parameters:
- ADDR_W, 15, instruction-memory address width; maximum program length is 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte; transfer occurs on a rising edge with rx_valid && rx_ready.
- rom_addr  out  ADDR_W  instruction-memory write address.
- rom_wdata  out  16  instruction word to write.
- rom_we  out  1  one-cycle write strobe.
- cpu_reset  out  1  drives the cpu reset input; high = cpu held.
- busy  out  1  frame reception in progress (after first byte accepted, before RUN/ERR).
- done  out  1  program loaded and verified; cpu running.
- error  out  1  frame rejected; sticky until reset.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high. While reset is high on a clock edge, all registers take their reset values.
  - Reset values: state=LEN_HI, rom_addr=0, rom_wdata=0, rom_we=0, cpu_reset=1, busy=0, done=0, error=0, length=0, sum=0.
  - rx_ready is forced 0 while reset is high.
- Frame format, all big-endian:
  - LEN_HI, LEN_LO: length N in words.
  - N×(W_HI, W_LO).
  - CSUM: 8-bit sum mod 256 of every preceding byte of the frame.
- States: LEN_HI, LEN_LO, W_HI, W_LO, CSUM, RUN, ERR.
  - rx_ready=1 in LEN_HI..CSUM and 0 in RUN and ERR.
  - A state advances only on an accepted byte. Each accepted byte before CSUM is added to sum.
- LEN_LO accept:
  - N = {hi, lo}.
  - If N==0 or N > 2^ADDR_W, go to ERR. Otherwise go to W_HI with word counter = 0.
- W_HI accept: latch high byte, go to W_LO.
- W_LO accept:
  - On the next cycle: rom_we=1, rom_wdata={hi,lo}, rom_addr=word counter. rom_we lasts exactly one cycle.
  - Counter increments. If counter+1 == N, go to CSUM, else go to W_HI.
  - rx_ready stays 1 during the write cycle; there are no bubbles.
- rom_addr / rom_wdata hold their last value while rom_we=0.
- CSUM accept:
  - If byte == sum, go to RUN: next cycle cpu_reset=0, done=1, busy=0.
  - Otherwise go to ERR: error=1, busy=0, cpu_reset stays 1.
- RUN and ERR are terminal until reset; rx_valid is ignored there.
- Words are written before checksum verification. This is harmless because the cpu is held until RUN.
- Counter width is ADDR_W+1 so that N = 2^ADDR_W is reachable without wrap. The last write address is 2^ADDR_W−1.
- busy goes 1 the cycle after the LEN_HI byte is accepted.
- Reset mid-frame: everything returns to reset values and the partial frame is discarded. The next byte is treated as LEN_HI. Already-written ROM words are not cleared.
- Simultaneous reset and rx_valid: reset wins and no byte is consumed.

Test Plan:
1. Valid frame, 2 words: bytes 00 02 40 00 EC 10 3E.
   - Writes addr0=0x4000 and addr1=0xEC10, each as a single rom_we pulse.
   - Cycle after CSUM accept: cpu_reset=0, done=1, error=0, rx_ready=0.
2. Bad checksum: same frame with last byte 3F.
   - Both writes still occur; then error=1, cpu_reset=1, done=0, rx_ready=0.
   - Further bytes are ignored.
3. Zero length: bytes 00 00.
   - error=1 the cycle after LEN_LO accept; no rom_we ever.
4. Back-pressure / gaps: frame 1 with rx_valid low for 1–3 random cycles between bytes, and rx_data garbage while invalid.
   - Result is identical to scenario 1.
5. Reset mid-load: assert reset for 1 cycle after bytes 00 02 40.
   - Outputs return to reset values; rx_ready=0 during the reset cycle.
   - A full frame 1 then loads and reaches done=1.
6. Length bound with ADDR_W=4:
   - N=17 (00 11) → error.
   - N=16 with 32 data bytes and correct sum → 16 writes, last rom_addr=15, done=1.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed, checksummed byte frame, writes the
// 16-bit words it carries into instruction memory from address 0 and releases
// the cpu reset only after the trailing checksum matches.
module boot_loader #(
  parameter int ADDR_W = 15  // legal range 1..16: the 16-bit length field must fit the bound check
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              rom_we,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra bit so that a full 2^ADDR_W-word program is countable without wrap.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_W_HI,
    S_W_LO,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

  state_e              state_q;
  logic [7:0]          hi_q;       // latched high byte of the length or of the current word
  logic [7:0]          sum_q;
  logic [16:0]         len_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [15:0]         rom_wdata_q;
  logic                rom_we_q;
  logic                cpu_reset_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;

  logic                accept;
  logic [7:0]          sum_d;
  logic [CNT_W-1:0]    cnt_d;
  logic [16:0]         len_full;
  logic                len_ok;

  // Handshake and next-value arithmetic shared by the state machine.
  always_comb begin
    rx_ready = !reset && (state_q != S_RUN) && (state_q != S_ERR);
    accept   = rx_valid && rx_ready;
    sum_d    = sum_q + rx_data;
    cnt_d    = cnt_q + CNT_W'(1);
    len_full = {1'b0, hi_q, rx_data};
    len_ok   = (len_full != 17'd0) && (len_full <= MAX_LEN);
  end

  // Frame parser, word writer and start-up sequencer; every output is registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LEN_HI;
      hi_q        <= '0;
      sum_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      rom_we_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here update from the
      // pre-edge values, so the default below and the later override in W_LO do
      // not race; the last assignment in program order wins.
      rom_we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          S_LEN_HI: begin
            hi_q    <= rx_data;
            sum_q   <= sum_d;
            busy_q  <= 1'b1;
            state_q <= S_LEN_LO;
          end
          S_LEN_LO: begin
            sum_q <= sum_d;
            cnt_q <= '0;
            if (len_ok) begin
              len_q   <= len_full;
              state_q <= S_W_HI;
            end else begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_ERR;
            end
          end
          S_W_HI: begin
            hi_q    <= rx_data;
            sum_q   <= sum_d;
            state_q <= S_W_LO;
          end
          S_W_LO: begin
            sum_q       <= sum_d;
            rom_we_q    <= 1'b1;
            rom_wdata_q <= {hi_q, rx_data};
            rom_addr_q  <= cnt_q[ADDR_W-1:0];
            cnt_q       <= cnt_d;
            state_q     <= (17'(cnt_d) == len_q) ? S_CSUM : S_W_HI;
          end
          S_CSUM: begin
            busy_q <= 1'b0;
            if (rx_data == sum_q) begin
              cpu_reset_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_RUN;
            end else begin
              error_q <= 1'b1;
              state_q <= S_ERR;
            end
          end
          default: ;  // RUN and ERR never accept a byte
        endcase
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign rom_we    = rom_we_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
